addsub_fu: RTL and testbench

Multi-cycle integer ADD/SUB functional unit for the scoreboard datapath.
- Accepts one issued instruction: opcode, two operands, destination tag.
- Computes a+b, or a-b as a + ~b + 1, on the 16-bit prefix carry-lookahead adder datapath.
- Holds the result, flags and tag until the scoreboard write-back stage grants the result bus.
- Completes the FU side of the issue / execute / write-result handshake.

---
 rtl/addsub_fu.sv | 195 +++++++++++++++++++
 tb/tb_addsub_fu.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_fu.sv
// ---------------------------------------------------------------------------
// addsub_fu -- multi-cycle integer ADD/SUB functional unit.
//
// This unit accepts one issued instruction. It computes a+b, or a-b as
// a + ~b + 1, on a Kogge-Stone prefix carry-lookahead adder. It then holds the
// result, the flags and the destination tag until write-back grants the
// result bus.
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   flush         synchronous abort of any in-flight operation (top priority)
//   issue_valid   scoreboard presents an instruction
//   issue_ready   FU can accept an instruction (IDLE)
//   op            0 = ADD, 1 = SUB
//   a, b          operands (Fj, Fk), sampled on the acceptance edge
//   dest_tag      destination register tag
//   busy          FU occupied (EXEC or WAIT_WB)
//   result_valid  result held, requesting write-back (WAIT_WB)
//   result        sum or difference
//   result_tag    tag of the held result
//   cout          carry out; for SUB, 1 means no borrow (a >= b unsigned)
//   overflow      signed two's-complement overflow
//   wb_grant      write-back consumes the result this cycle
// ---------------------------------------------------------------------------
module addsub_fu #(
    parameter int WIDTH   = 16,
    parameter int TAGW    = 4,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAGW-1:0]  dest_tag,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic [TAGW-1:0]  result_tag,
    output logic             cout,
    output logic             overflow,
    input  logic             wb_grant
);

    localparam int LEVELS = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXEC    = 2'd1;
    localparam logic [1:0] S_WAIT_WB = 2'd2;

    // The counter is wide enough for the full legal LATENCY range of 1..15.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             op_q, op_d;
    logic [TAGW-1:0]  tag_q, tag_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [TAGW-1:0]  res_tag_q, res_tag_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // -----------------------------------------------------------------------
    // Prefix adder on the latched operands. The SUB carry-in is folded into
    // the bit-0 generate, so the tree produces every carry, including cout.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] b_eff, p_raw, g_pf, p_pf, g_nx, p_nx, carry, sum;
    logic             sum_cout, sum_ovf;

    assign b_eff = op_q ? ~b_q : b_q;
    assign p_raw = a_q ^ b_eff;

    always_comb begin
        g_pf    = a_q & b_eff;
        g_pf[0] = g_pf[0] | (p_raw[0] & op_q);
        p_pf    = p_raw;
        g_nx    = '0;
        p_nx    = '0;
        for (int lv = 0; lv < LEVELS; lv++) begin
            g_nx = g_pf;
            p_nx = p_pf;
            for (int i = (1 << lv); i < WIDTH; i++) begin
                g_nx[i] = g_pf[i] | (p_pf[i] & g_pf[i - (1 << lv)]);
                p_nx[i] = p_pf[i] & p_pf[i - (1 << lv)];
            end
            g_pf = g_nx;
            p_pf = p_nx;
        end
    end

    // The carry into bit i is the group generate of bits [i-1:0] together
    // with the carry-in.
    assign carry    = {g_pf[WIDTH-2:0], op_q};
    assign sum      = p_raw ^ carry;
    assign sum_cout = g_pf[WIDTH-1];
    assign sum_ovf  = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);

    // -----------------------------------------------------------------------
    // Control
    // -----------------------------------------------------------------------
    // NOTE: every _d signal gets its hold value first, so no path through
    // this block can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        tag_d     = tag_q;
        res_d     = res_q;
        res_tag_d = res_tag_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (issue_valid) begin
                        state_d = S_EXEC;
                        cnt_d   = CNT_LOAD;
                        a_d     = a;
                        b_d     = b;
                        op_d    = op;
                        tag_d   = dest_tag;
                    end
                end
                S_EXEC: begin
                    if (cnt_q == '0) begin
                        state_d   = S_WAIT_WB;
                        res_d     = sum;
                        res_tag_d = tag_q;
                        cout_d    = sum_cout;
                        ovf_d     = sum_ovf;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_WAIT_WB: begin
                    if (wb_grant) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge value no matter how the blocks are ordered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 1'b0;
            tag_q     <= '0;
            res_q     <= '0;
            res_tag_q <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            res_q     <= res_d;
            res_tag_q <= res_tag_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    // Handshake outputs decode the state alone and never look at issue_valid.
    assign issue_ready  = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign result_valid = (state_q == S_WAIT_WB);
    assign result       = res_q;
    assign result_tag   = res_tag_q;
    assign cout         = cout_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_addsub_fu.sv
// ---------------------------------------------------------------------------
// tb_addsub_fu -- self-checking bench for addsub_fu (WIDTH=16, LATENCY=2).
// The reference model computes results with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_addsub_fu;

    localparam int WIDTH   = 16;
    localparam int TAGW    = 4;
    localparam int LATENCY = 2;
    localparam int TIMEOUT = 50;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             issue_valid = 1'b0;
    logic             issue_ready;
    logic             op = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [TAGW-1:0]  dest_tag = '0;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic [TAGW-1:0]  result_tag;
    logic             cout;
    logic             overflow;
    logic             wb_grant = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    addsub_fu #(.WIDTH(WIDTH), .TAGW(TAGW), .LATENCY(LATENCY)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .op           (op),
        .a            (a),
        .b            (b),
        .dest_tag     (dest_tag),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .result_tag   (result_tag),
        .cout         (cout),
        .overflow     (overflow),
        .wb_grant     (wb_grant)
    );

    always #5 clk = ~clk;

    // Reference model: returns {overflow, cout, result[15:0]}.
    function automatic logic [17:0] model(input logic m_op, input logic [15:0] ma,
                                          input logic [15:0] mb);
        int unsigned ua, ub, s;
        int          sa, sb, sr;
        logic        ovf;
        logic [15:0] nb;
        nb = ~mb;
        ua = ma;
        ub = m_op ? nb : mb;
        s  = ua + ub + (m_op ? 1 : 0);
        sa = $signed(ma);
        sb = $signed(mb);
        sr = m_op ? (sa - sb) : (sa + sb);
        ovf = (sr > 32767) || (sr < -32768);
        return {ovf, s[16], s[15:0]};
    endfunction

    // This task drives one instruction and reports what the DUT produced. It
    // performs no checks itself. lat is the number of edges from acceptance to
    // result_valid, or TIMEOUT if result_valid never rises.
    task automatic exec_op(input logic t_op, input logic [15:0] ta, input logic [15:0] tb_v,
                           input logic [3:0] ttag, output int lat, output logic busy_after,
                           output logic [15:0] r, output logic c, output logic v,
                           output logic [3:0] t);
        @(negedge clk);
        issue_valid = 1'b1;
        op          = t_op;
        a           = ta;
        b           = tb_v;
        dest_tag    = ttag;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        a           = 16'($urandom);
        b           = 16'($urandom);
        op          = 1'($urandom);
        dest_tag    = 4'($urandom);
        busy_after  = busy;
        lat         = 0;
        while (!result_valid && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = result;
        c = cout;
        v = overflow;
        t = result_tag;
    endtask

    task automatic grant_once();
        @(negedge clk);
        wb_grant = 1'b1;
        @(posedge clk);
        #1;
        wb_grant = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests_run++;
        if ({result_valid, busy, cout, overflow} !== 4'b0000) begin
            $display("FAIL reset_flags: rv/busy/cout/ovf=%b expected 0000",
                     {result_valid, busy, cout, overflow});
            tests_failed++;
        end
        tests_run++;
        if ({result, result_tag} !== 20'h0) begin
            $display("FAIL reset_data: result=%h tag=%h expected 0/0", result, result_tag);
            tests_failed++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (issue_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL reset_release: ready=%b busy=%b expected 1/0", issue_ready, busy);
            tests_failed++;
        end
    endtask

    // Directed arithmetic: {op, a, b, expected result, cout, overflow}.
    task automatic test_directed();
        logic [0:0]  d_op  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] d_a   [6] = '{16'h1234, 16'h0005, 16'h0003, 16'h7FFF, 16'h8000, 16'hFFFF};
        logic [15:0] d_b   [6] = '{16'h0F0F, 16'h0003, 16'h0005, 16'h0001, 16'h0001, 16'h0001};
        logic [15:0] d_r   [6] = '{16'h2143, 16'h0002, 16'hFFFE, 16'h8000, 16'h7FFF, 16'h0000};
        logic        d_c   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        d_v   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int lat;
        logic bz, c, v;
        logic [15:0] r;
        logic [3:0] t;
        for (int k = 0; k < 6; k++) begin
            exec_op(d_op[k][0], d_a[k], d_b[k], 4'(k + 3), lat, bz, r, c, v, t);
            tests_run++;
            if (lat !== LATENCY || bz !== 1'b1) begin
                $display("FAIL directed_latency[%0d]: edges=%0d busy=%b expected %0d/1",
                         k, lat, bz, LATENCY);
                tests_failed++;
            end
            tests_run++;
            if (r !== d_r[k] || c !== d_c[k] || v !== d_v[k] || t !== 4'(k + 3)) begin
                $display("FAIL directed_result[%0d]: r=%h c=%b v=%b tag=%h expected r=%h c=%b v=%b tag=%h",
                         k, r, c, v, t, d_r[k], d_c[k], d_v[k], 4'(k + 3));
                tests_failed++;
            end
            grant_once();
            tests_run++;
            if (result_valid !== 1'b0 || issue_ready !== 1'b1) begin
                $display("FAIL directed_grant[%0d]: rv=%b ready=%b expected 0/1",
                         k, result_valid, issue_ready);
                tests_failed++;
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic bz, c, v;
        logic [15:0] r;
        logic [3:0] t;
        logic [17:0] exp;
        int bad;
        exp = model(1'b1, 16'h4000, 16'hC123);
        exec_op(1'b1, 16'h4000, 16'hC123, 4'hA, lat, bz, r, c, v, t);
        tests_run++;
        if (lat !== LATENCY || {v, c, r} !== exp || t !== 4'hA) begin
            $display("FAIL bp_result: edges=%0d r=%h c=%b v=%b tag=%h expected %0d {v,c,r}=%h tag=a",
                     lat, r, c, v, t, LATENCY, exp);
            tests_failed++;
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            issue_valid = 1'b1;
            op          = 1'b0;
            a           = 16'h1111;
            b           = 16'h2222;
            dest_tag    = 4'h5;
            @(posedge clk);
            #1;
            if (result !== r || cout !== c || overflow !== v || result_tag !== t ||
                busy !== 1'b1 || issue_ready !== 1'b0 || result_valid !== 1'b1)
                bad++;
        end
        tests_run++;
        if (bad != 0) begin
            $display("FAIL bp_hold: %0d unstable cycles expected 0", bad);
            tests_failed++;
        end
        @(negedge clk);
        issue_valid = 1'b0;
        wb_grant    = 1'b1;
        @(posedge clk);
        #1;
        wb_grant = 1'b0;
        tests_run++;
        if (result_valid !== 1'b0 || issue_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL bp_grant: rv=%b ready=%b busy=%b expected 0/1/0",
                     result_valid, issue_ready, busy);
            tests_failed++;
        end
    endtask

    task automatic test_flush();
        int seen;
        // Flush on the first EXEC cycle.
        @(negedge clk);
        issue_valid = 1'b1;
        op          = 1'b0;
        a           = 16'h0101;
        b           = 16'h0202;
        dest_tag    = 4'h7;
        @(posedge clk);
        @(negedge clk);
        issue_valid = 1'b0;
        flush       = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || issue_ready !== 1'b1 || result_valid !== 1'b0) begin
            $display("FAIL flush_exec: busy=%b ready=%b rv=%b expected 0/1/0",
                     busy, issue_ready, result_valid);
            tests_failed++;
        end
        seen = 0;
        for (int k = 0; k < 2 * LATENCY + 4; k++) begin
            @(posedge clk);
            #1;
            if (result_valid === 1'b1 || busy === 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            $display("FAIL flush_no_result: %0d active cycles expected 0", seen);
            tests_failed++;
        end
        // A flush in IDLE drops the simultaneous issue.
        @(negedge clk);
        issue_valid = 1'b1;
        flush       = 1'b1;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        flush       = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || issue_ready !== 1'b1) begin
            $display("FAIL flush_idle_issue: busy=%b ready=%b expected 0/1", busy, issue_ready);
            tests_failed++;
        end
        seen = 0;
        for (int k = 0; k < 2 * LATENCY + 4; k++) begin
            @(posedge clk);
            #1;
            if (result_valid === 1'b1 || busy === 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            $display("FAIL flush_idle_quiet: %0d active cycles expected 0", seen);
            tests_failed++;
        end
    endtask

    task automatic test_async_reset();
        int lat;
        logic bz, c, v;
        logic [15:0] r;
        logic [3:0] t;
        exec_op(1'b0, 16'hFFFF, 16'hFFFF, 4'hF, lat, bz, r, c, v, t);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({result_valid, busy, cout, overflow} !== 4'b0000 || result !== 16'h0 ||
            result_tag !== 4'h0 || issue_ready !== 1'b1) begin
            $display("FAIL async_reset: rv=%b busy=%b c=%b v=%b r=%h tag=%h ready=%b expected all 0, ready 1",
                     result_valid, busy, cout, overflow, result, result_tag, issue_ready);
            tests_failed++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        exec_op(1'b0, 16'h0001, 16'h0001, 4'h2, lat, bz, r, c, v, t);
        tests_run++;
        if (lat !== LATENCY || r !== 16'h0002 || c !== 1'b0 || v !== 1'b0 || t !== 4'h2) begin
            $display("FAIL async_reset_recover: edges=%0d r=%h c=%b v=%b tag=%h expected %0d 0002 0 0 2",
                     lat, r, c, v, t, LATENCY);
            tests_failed++;
        end
        grant_once();
    endtask

    task automatic test_random();
        int lat, delay;
        logic bz, c, v, rop;
        logic [15:0] r, ra, rb;
        logic [3:0] t, rt;
        logic [17:0] exp;
        for (int k = 0; k < 40; k++) begin
            rop = 1'($urandom);
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rt  = 4'($urandom);
            if (k % 8 == 0) ra = 16'h8000;
            if (k % 8 == 1) rb = 16'h7FFF;
            if (k % 8 == 2) rb = ra;
            exp = model(rop, ra, rb);
            exec_op(rop, ra, rb, rt, lat, bz, r, c, v, t);
            delay = $urandom_range(0, 3);
            repeat (delay) @(posedge clk);
            #1;
            tests_run++;
            if (lat !== LATENCY || {v, c, r} !== exp || t !== rt ||
                result !== r || result_valid !== 1'b1) begin
                $display("FAIL random[%0d]: op=%b a=%h b=%h edges=%0d {v,c,r}=%h tag=%h expected {v,c,r}=%h tag=%h",
                         k, rop, ra, rb, lat, {v, c, r}, t, exp, rt);
                tests_failed++;
            end
            grant_once();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
